sprite_dma_ctrl: RTL and testbench
==================================

Name: sprite_dma_ctrl

Overview:
- Bus-sharing controller for the 6502 core's external bus. It implements the $4014 sprite DMA: a CPU write of a page number halts the core through RDY, takes the address/data bus, and copies 256 bytes from {page,$00..$FF} to a fixed destination register.
- Sits between Core6502 pads and the system bus mux; DMA_GRANT drives the mux select.
- One bus cycle per clock.

Parameters:
- REG_ADDR, 16'h4014, trigger register address.
- DEST_ADDR, 16'h2004, write destination for every byte.

Ports:
- PHI0  in  1  reference clock; all state updates on rising edge.
- RES  in  1  synchronous reset, active-high.
- CPU_A  in  16  core address bus.
- CPU_RnW  in  1  core R/W (1 = read).
- CPU_D  in  8  core write data, used for the trigger.
- BUS_D  in  8  system data bus read value, sampled on DMA read cycles.
- RDY  out  1  to core RDY pad (0 = halt).
- DMA_GRANT  out  1  1 = DMA owns the bus.
- DMA_A  out  16  DMA address.
- DMA_RnW  out  1  DMA R/W.
- DMA_D  out  8  DMA write data.
- BUSY  out  1  transfer pending or active.

Behaviour:
- All outputs are registered.
- Reset values:
  - RDY=1, DMA_GRANT=0, DMA_A=0, DMA_RnW=1, DMA_D=0, BUSY=0.
  - Internal: state=IDLE, idx=0, page=0, parity=0.
- Parity:
  - Toggles every clock and is cleared by RES.
  - parity=0 is a GET (read) cycle; parity=1 is a PUT (write) cycle.
- Trigger:
  - Condition: in IDLE, DMA_GRANT=0, CPU_RnW=0 and CPU_A==REG_ADDR in cycle t0.
  - At the end of t0: page<=CPU_D, idx<=0, state<=HALT.
  - From t1: RDY=0, BUSY=1.
  - Trigger conditions arising in any non-IDLE state are ignored.
  - A read of REG_ADDR never triggers.
- HALT:
  - RDY=0, DMA_GRANT=0.
  - A core write cycle (CPU_RnW=0) means the core ignores RDY, so the controller stays in HALT.
  - The first cycle with CPU_RnW=1 is the stalled cycle. Next state is READ if the next cycle's parity=0, otherwise ALIGN.
- ALIGN:
  - One cycle with DMA_GRANT=1, DMA_RnW=1, DMA_A={page,idx} (dummy read).
  - Then READ.
- READ (always a GET cycle):
  - DMA_GRANT=1, DMA_RnW=1, DMA_A={page,idx}.
  - At the end of the cycle: DMA_D<=BUS_D, state<=WRITE.
- WRITE (always a PUT cycle):
  - DMA_GRANT=1, DMA_RnW=0, DMA_A=DEST_ADDR, DMA_D holds the byte latched in READ.
  - At the end of the cycle: idx<=idx+1 (8-bit, wraps).
  - If idx was 8'hFF: state<=IDLE. The next cycle has RDY=1, DMA_GRANT=0, BUSY=0, DMA_RnW=1.
  - Otherwise state<=READ.
- Address arithmetic:
  - idx never carries into page; the address after {page,$FF} is DEST_ADDR, not {page+1,$00}.
- Transfer length:
  - Exactly 256 READ/WRITE pairs, i.e. 512 granted cycles plus 0/1 ALIGN cycle.
  - RDY low time = HALT cycles (>=1) + ALIGN (0/1) + 512. With an immediate core read this is 513 or 514 cycles.
- Outside a grant:
  - DMA_A holds its last value; DMA_RnW=1.
- Reset mid-operation:
  - RES in any state forces reset values at the next edge: the transfer is abandoned and the next cycle has RDY=1.
  - A later trigger restarts from idx=0.
- Simultaneity:
  - RES has priority over a trigger in the same cycle (no transfer starts).
  - A trigger in the same cycle as the final WRITE is ignored: the state is not IDLE.

Test Plan:
- Basic transfer
  - Stimulus: reset, run 1 cycle, write $02 to $4014, core then issues only reads, memory[$02nn]=nn^$5A.
  - Required response: RDY low 513 or 514 cycles matching parity rule. DMA reads $0200..$02FF in order, each followed by a write to $2004 carrying nn^$5A. BUSY drops with RDY.
- Alignment
  - Stimulus: run the basic trigger once at each parity.
  - Required response: one case shows exactly one ALIGN cycle (total 514); the other shows none (total 513). Every READ has parity=0 and every WRITE has parity=1.
- Core writes during HALT
  - Stimulus: trigger followed by 3 core write cycles (CPU_RnW=0), then a read.
  - Required response: DMA_GRANT stays 0 for those 3 cycles plus the stalled read cycle. The transfer then completes with 256 pairs.
- Non-trigger accesses and retrigger
  - Stimulus: write to $4015, read of $4014, and a write to $4014 mid-transfer.
  - Required response: no BUSY from the first two. The mid-transfer write does not change page or idx; destination writes continue at the original page.
- Reset mid-transfer
  - Stimulus: assert RES when idx=$80 during WRITE.
  - Required response: next cycle RDY=1, DMA_GRANT=0, BUSY=0, DMA_A=0. A new trigger with page $03 starts at $0300.
- Page wrap
  - Stimulus: trigger with page $FF.
  - Required response: last read address is $FFFF, followed by a write to $2004, then IDLE. Address $0000 is never driven by a DMA read.

Source files
------------

// File: rtl/sprite_dma_ctrl.sv
// Sprite DMA controller: a write of a page number to REG_ADDR halts the 6502 via RDY
// and copies 256 bytes from {page,$00..$FF} to DEST_ADDR, one bus cycle per clock.
module sprite_dma_ctrl #(
    parameter logic [15:0] REG_ADDR  = 16'h4014,
    parameter logic [15:0] DEST_ADDR = 16'h2004
) (
    input  logic        PHI0,
    input  logic        RES,
    input  logic [15:0] CPU_A,
    input  logic        CPU_RnW,
    input  logic [7:0]  CPU_D,
    input  logic [7:0]  BUS_D,
    output logic        RDY,
    output logic        DMA_GRANT,
    output logic [15:0] DMA_A,
    output logic        DMA_RnW,
    output logic [7:0]  DMA_D,
    output logic        BUSY
);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic        parity_q;

    logic        rdy_q, rdy_d;
    logic        grant_q, grant_d;
    logic [15:0] dmaAddr_q, dmaAddr_d;
    logic        dmaRnW_q, dmaRnW_d;
    logic [7:0]  dmaData_q, dmaData_d;
    logic        busy_q, busy_d;

    always_ff @(posedge PHI0) begin
        if (RES) begin
            state_q   <= IDLE;
            idx_q     <= 8'h00;
            page_q    <= 8'h00;
            parity_q  <= 1'b0;
            rdy_q     <= 1'b1;
            grant_q   <= 1'b0;
            dmaAddr_q <= 16'h0000;
            dmaRnW_q  <= 1'b1;
            dmaData_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            page_q    <= page_d;
            parity_q  <= ~parity_q;
            rdy_q     <= rdy_d;
            grant_q   <= grant_d;
            dmaAddr_q <= dmaAddr_d;
            dmaRnW_q  <= dmaRnW_d;
            dmaData_q <= dmaData_d;
            busy_q    <= busy_d;
        end
    end

    // HALT leaves on the stalled read; an ALIGN is inserted so READ lands on a GET cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        case (state_q)
            IDLE: begin
                if (!grant_q && !CPU_RnW && (CPU_A == REG_ADDR)) begin
                    page_d  = CPU_D;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end
            HALT: begin
                if (CPU_RnW) begin
                    state_d = parity_q ? READ : ALIGN;
                end
            end
            ALIGN: state_d = READ;
            READ:  state_d = WRITE;
            WRITE: begin
                idx_d   = idx_q + 8'h01;
                state_d = (idx_q == 8'hFF) ? IDLE : READ;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        rdy_d     = (state_d == IDLE);
        busy_d    = (state_d != IDLE);
        grant_d   = (state_d == ALIGN) || (state_d == READ) || (state_d == WRITE);
        dmaRnW_d  = (state_d != WRITE);
        dmaAddr_d = dmaAddr_q;
        if ((state_d == ALIGN) || (state_d == READ)) begin
            dmaAddr_d = {page_d, idx_d};
        end else if (state_d == WRITE) begin
            dmaAddr_d = DEST_ADDR;
        end
        dmaData_d = (state_q == READ) ? BUS_D : dmaData_q;
    end

    assign RDY       = rdy_q;
    assign DMA_GRANT = grant_q;
    assign DMA_A     = dmaAddr_q;
    assign DMA_RnW   = dmaRnW_q;
    assign DMA_D     = dmaData_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_sprite_dma_ctrl.sv
// Self-checking bench for sprite_dma_ctrl: a table of single-cycle idle/trigger vectors,
// then whole transfers checked cycle by cycle against a parity-tracking transfer model.
module tb_sprite_dma_ctrl;

    localparam logic [15:0] REG  = 16'h4014;
    localparam logic [15:0] DEST = 16'h2004;

    logic        PHI0;
    logic        RES;
    logic [15:0] CPU_A;
    logic        CPU_RnW;
    logic [7:0]  CPU_D;
    logic [7:0]  BUS_D;
    logic        RDY;
    logic        DMA_GRANT;
    logic [15:0] DMA_A;
    logic        DMA_RnW;
    logic [7:0]  DMA_D;
    logic        BUSY;

    sprite_dma_ctrl #(.REG_ADDR(REG), .DEST_ADDR(DEST)) dut (
        .PHI0(PHI0), .RES(RES), .CPU_A(CPU_A), .CPU_RnW(CPU_RnW), .CPU_D(CPU_D),
        .BUS_D(BUS_D), .RDY(RDY), .DMA_GRANT(DMA_GRANT), .DMA_A(DMA_A),
        .DMA_RnW(DMA_RnW), .DMA_D(DMA_D), .BUSY(BUSY)
    );

    initial begin
        PHI0 = 1'b0;
        forever #5 PHI0 = ~PHI0;
    end

    int tests = 0;
    int failures = 0;

    // Model state: parity of the current cycle and the values the DMA outputs hold.
    bit          par = 1'b0;
    logic [15:0] lastA = 16'h0000;
    logic [7:0]  lastD = 8'h00;
    logic [7:0]  key = 8'h5A;
    bit          seenAlign [2];

    int zeroReads = 0;
    always @(negedge PHI0) begin
        if (DMA_GRANT === 1'b1 && DMA_RnW === 1'b1 && DMA_A === 16'h0000) zeroReads++;
    end

    typedef struct {
        bit          res;
        logic [15:0] a;
        bit          rnw;
        logic [7:0]  d;
        bit          eRdy;
        bit          eBusy;
    } vec_t;

    task automatic applyStimulus(input bit res, input logic [15:0] a, input bit rnw,
                                 input logic [7:0] d);
        RES     = res;
        CPU_A   = a;
        CPU_RnW = rnw;
        CPU_D   = d;
    endtask

    task automatic step();
        bit r;
        r = RES;
        @(posedge PHI0);
        #1;
        par = r ? 1'b0 : ~par;
    endtask

    task automatic checkOutput(input string name, input bit eRdy, input bit eGrant,
                               input bit eRnW, input bit eBusy, input logic [15:0] eA,
                               input logic [7:0] eD);
        logic [27:0] act;
        logic [27:0] exp;
        act = {RDY, DMA_GRANT, DMA_RnW, BUSY, DMA_A, DMA_D};
        exp = {eRdy, eGrant, eRnW, eBusy, eA, eD};
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got rdy=%b gnt=%b rnw=%b busy=%b a=%h d=%h, want rdy=%b gnt=%b rnw=%b busy=%b a=%h d=%h",
                     name, RDY, DMA_GRANT, DMA_RnW, BUSY, DMA_A, DMA_D,
                     eRdy, eGrant, eRnW, eBusy, eA, eD);
        end
    endtask

    task automatic expectIdle(input string name);
        checkOutput(name, 1'b1, 1'b0, 1'b1, 1'b0, lastA, lastD);
    endtask

    function automatic logic [15:0] randAddr();
        logic [15:0] a;
        a = 16'($urandom);
        if (a == REG) a = a ^ 16'h0001;
        return a;
    endfunction

    task automatic quietStimulus();
        if ($urandom_range(0, 1) == 0) applyStimulus(1'b0, REG, 1'b1, 8'($urandom));
        else applyStimulus(1'b0, randAddr(), 1'b0, 8'($urandom));
    endtask

    task automatic runIdle(input int n);
        for (int k = 0; k < n; k++) begin
            quietStimulus();
            step();
            expectIdle("idleGap");
        end
    endtask

    task automatic busStimulus(input bit noise, input bit forceTrig, input logic [7:0] page);
        if (forceTrig) applyStimulus(1'b0, REG, 1'b0, ~page);
        else if (noise && $urandom_range(0, 1) == 1) applyStimulus(1'b0, REG, 1'b0, 8'($urandom));
        else applyStimulus(1'b0, randAddr(), 1'($urandom), 8'($urandom));
    endtask

    // Runs one transfer from the trigger cycle (the current cycle) to completion or abort.
    task automatic runTransfer(input logic [7:0] page, input int haltWrites, input bit noise,
                               input int abortAt);
        int rdyLow;
        bit aligned;
        rdyLow  = 0;
        aligned = 1'b0;
        applyStimulus(1'b0, REG, 1'b0, page);
        step();
        for (int h = 0; h <= haltWrites; h++) begin
            checkOutput("halt", 1'b0, 1'b0, 1'b1, 1'b1, lastA, lastD);
            if (RDY === 1'b0) rdyLow++;
            applyStimulus(1'b0, randAddr(), (h == haltWrites), 8'($urandom));
            step();
        end
        if (par) begin
            aligned = 1'b1;
            lastA   = {page, 8'h00};
            checkOutput("align", 1'b0, 1'b1, 1'b1, 1'b1, lastA, lastD);
            if (RDY === 1'b0) rdyLow++;
            busStimulus(noise, 1'b0, page);
            step();
        end
        seenAlign[aligned] = 1'b1;
        for (int i = 0; i < 256; i++) begin
            lastA = {page, 8'(i)};
            checkOutput("read", 1'b0, 1'b1, 1'b1, 1'b1, lastA, lastD);
            if (RDY === 1'b0) rdyLow++;
            BUS_D = DMA_A[7:0] ^ key;
            busStimulus(noise, 1'b0, page);
            step();
            lastD = 8'(i) ^ key;
            lastA = DEST;
            checkOutput("write", 1'b0, 1'b1, 1'b0, 1'b1, lastA, lastD);
            if (RDY === 1'b0) rdyLow++;
            if (i == abortAt) begin
                applyStimulus(1'b1, REG, 1'b0, 8'($urandom));
                step();
                lastA = 16'h0000;
                lastD = 8'h00;
                checkOutput("resetMid", 1'b1, 1'b0, 1'b1, 1'b0, lastA, lastD);
                applyStimulus(1'b0, 16'h0000, 1'b1, 8'h00);
                return;
            end
            busStimulus(noise, noise && (i == 255), page);
            step();
        end
        expectIdle("done");
        tests++;
        if (rdyLow != 1 + haltWrites + int'(aligned) + 512) begin
            failures++;
            $display("[TB] FAIL rdyLowCycles: got %0d, want %0d", rdyLow,
                     1 + haltWrites + int'(aligned) + 512);
        end
    endtask

    vec_t vecs [7];

    initial begin
        int z0;
        vecs[0] = '{1'b1, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'h4015, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[2] = '{1'b0, REG,      1'b1, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{1'b1, REG,      1'b0, 8'h02, 1'b1, 1'b0};
        vecs[4] = '{1'b0, REG,      1'b0, 8'h07, 1'b0, 1'b1};
        vecs[5] = '{1'b1, REG,      1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b0};
        BUS_D = 8'h00;
        applyStimulus(1'b1, 16'h0000, 1'b1, 8'h00);
        step();

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].res, vecs[v].a, vecs[v].rnw, vecs[v].d);
            step();
            checkOutput($sformatf("vec%0d", v), vecs[v].eRdy, 1'b0, 1'b1, vecs[v].eBusy,
                        16'h0000, 8'h00);
        end

        applyStimulus(1'b1, 16'h0000, 1'b1, 8'h00);
        step();
        expectIdle("reset");
        runIdle(1);
        key = 8'h5A;
        runTransfer(8'h02, 0, 1'b0, -1);
        runTransfer(8'h02, 0, 1'b0, -1);
        tests++;
        if (!(seenAlign[0] && seenAlign[1])) begin
            failures++;
            $display("[TB] FAIL alignBoth: got noAlign=%b align=%b, want 1 1",
                     seenAlign[0], seenAlign[1]);
        end

        runIdle(2);
        runTransfer(8'h11, 3, 1'b0, -1);
        runIdle(1);
        runTransfer(8'h22, 0, 1'b1, -1);
        runIdle(3);
        expectIdle("afterRetrigger");

        runTransfer(8'h05, 1, 1'b0, 128);
        runIdle(1);
        runTransfer(8'h03, 0, 1'b0, -1);

        z0 = zeroReads;
        runIdle(1);
        runTransfer(8'hFF, 0, 1'b0, -1);
        tests++;
        if (zeroReads != z0) begin
            failures++;
            $display("[TB] FAIL pageWrapZeroRead: got %0d reads of 0000, want 0", zeroReads - z0);
        end

        for (int r = 0; r < 5; r++) begin
            key = 8'($urandom);
            runIdle($urandom_range(0, 3));
            runTransfer(8'($urandom), $urandom_range(0, 3), 1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
